sequenciador_porta: RTL and testbench
=====================================

SEQUENCIADOR_PORTA -- requirements
Module: sequenciador_porta

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 4, giving the width of the dwell-count input.
REQ-002 The block SHALL have port clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to play one full door sequence.
REQ-005 The block SHALL have port dwell, input, DWELL_W bits: number of clock cycles each code is held, minus one.
REQ-006 The block SHALL have port led_verde, input, 2 bits: green LED pair returned by the door controller.
REQ-007 The block SHALL have port led_vermelho, input, 2 bits: red LED pair returned by the door controller.
REQ-008 The block SHALL have port codigo, output, 4 bits: sensor code driven into the door controller.
REQ-009 The block SHALL have port passo, output, 3 bits: index of the current step, 0-5.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a sequence is playing.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a sequence.
REQ-012 The block SHALL have port erro, output, 1 bit: sticky flag, set on any LED mismatch.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, PLAY and FIM.
REQ-014 In IDLE, start=1 SHALL be accepted. On the next edge: enter PLAY, passo=0, load the dwell counter, clear erro.
REQ-015 start SHALL be ignored in PLAY and FIM.
REQ-016 In PLAY, codigo SHALL equal the step table entry for passo: 0000, 1100, 1101, 0110, 1010, 1000 for steps 0-5.
REQ-017 Effective dwell SHALL be max(dwell,1)+1 cycles per step (dwell=0 is treated as 1), so the controller gets at least one edge to respond.
REQ-018 The dwell counter SHALL count down. On each step's last cycle (counter=0), led_verde/led_vermelho SHALL be compared with that step's expected table entry; any mismatch sets erro.
REQ-019 On a step's last cycle with passo<5: passo increments and the counter reloads. With passo=5: go to FIM.
REQ-020 FIM SHALL last exactly one cycle with done=1, then go to IDLE. Because FIM is exited unconditionally, start is never accepted on the cycle done is high.
REQ-021 In IDLE and FIM, codigo SHALL be 0000 and passo SHALL be 0.
REQ-022 busy SHALL be 1 in PLAY only.
REQ-023 erro SHALL hold its value until the next accepted start or reset.
REQ-024 dwell SHALL be sampled at every counter reload. A change mid-step takes effect from the next step.
REQ-025 Total latency from start acceptance to the done pulse SHALL be 6*(max(dwell,1)+1)+1 cycles.

Reset
REQ-026 Asserting reset at any time, including mid-sequence, SHALL immediately force: state IDLE, codigo=0000, passo=0, busy=0, done=0, erro=0, counter=0.
REQ-027 After reset deasserts, the block SHALL accept start on the first rising edge.

Structure
REQ-028 A shared package SHALL hold: the state enumeration, the 6-entry step code table, the expected LED tables, and the constant N_PASSOS=6.
REQ-029 Expected LED tables (verde/vermelho) SHALL be, per step 0-5: 00/11, 01/10, 11/00, 10/01, 01/01, 00/11.
REQ-030 The dwell down-counter SHALL be one sub-module, contador_espera (load, enable, zero flag). The FSM and comparator SHALL stay in sequenciador_porta.

Verification
REQ-031 Reset then start=1, dwell=1, LEDs driven to match every step: codigo steps 0000→1100→1101→0110→1010→1000, 2 cycles each; done pulses once 13 cycles after acceptance; erro=0.
REQ-032 Same run, but at step 2 drive led_verde=00: erro=1 from step 2's last cycle onward; still at 1 after done; cleared by the next accepted start.
REQ-033 dwell=0: each code held 2 cycles, same as dwell=1. dwell=15: each code held 16 cycles; done after 97 cycles.
REQ-034 Pulse start during PLAY at step 3: no restart; passo continues 3→4→5; exactly one done pulse.
REQ-035 Assert reset during step 4: codigo=0000, busy=0, passo=0, erro=0 immediately, with no clock edge needed. Next start replays from step 0.
REQ-036 Hold start=1 continuously: done high for one cycle, IDLE for one cycle, then a new sequence starts; erro cleared at each new acceptance.

Source files
------------

// File: rtl/sequenciador_porta_pkg.sv
// Shared definitions for the door test sequencer: FSM states, the sensor code
// played at each step and the LED pattern the door controller must answer with.
package sequenciador_porta_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    FIM  = 2'd2
  } estado_t;

  localparam int N_PASSOS = 6;
  localparam logic [2:0] ULTIMO_PASSO = 3'(N_PASSOS - 1);

  localparam logic [3:0] TAB_CODIGO [N_PASSOS] = '{
    4'b0000, 4'b1100, 4'b1101, 4'b0110, 4'b1010, 4'b1000
  };

  localparam logic [1:0] TAB_VERDE [N_PASSOS] = '{
    2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 2'b00
  };

  localparam logic [1:0] TAB_VERMELHO [N_PASSOS] = '{
    2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11
  };

endpackage

// File: rtl/sequenciador_porta_contador_espera.sv
// Dwell down-counter: loads a hold length, counts down to zero while enabled
// and flags the last cycle of the current step.
module contador_espera #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] valor,
  output logic         zero
);

  logic [W-1:0] cont;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cont <= '0;
    end else if (load) begin
      cont <= valor;
    end else if (enable && (cont != '0)) begin
      cont <= cont - W'(1);
    end
  end

  assign zero = (cont == '0);

endmodule

// File: rtl/sequenciador_porta.sv
// Plays the six-step sensor code sequence into the door controller and checks
// the returned LED pair on the last cycle of each step.
module sequenciador_porta
  import sequenciador_porta_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [1:0]         led_verde,
  input  logic [1:0]         led_vermelho,
  output logic [3:0]         codigo,
  output logic [2:0]         passo,
  output logic               busy,
  output logic               done,
  output logic               erro,
  output estado_t            estado
);

  // start is a level request sampled only in IDLE; there is no ready/ack,
  // busy/done tell the requester when the sequence runs and when it ends.

  estado_t            estado_q, estado_d;
  logic [2:0]         passo_q;
  logic               cont_zero;
  logic               carregar;
  logic               ultimo_ciclo;
  logic               divergencia;
  logic [DWELL_W-1:0] valor_carga;

  // dwell=0 is stretched to 1 so the controller always sees an edge per code.
  assign valor_carga  = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign ultimo_ciclo = (estado_q == PLAY) && cont_zero;
  assign divergencia  = (led_verde != TAB_VERDE[passo_q]) ||
                        (led_vermelho != TAB_VERMELHO[passo_q]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= IDLE;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    carregar = 1'b0;
    case (estado_q)
      IDLE: begin
        if (start) begin
          estado_d = PLAY;
          carregar = 1'b1;
        end
      end
      PLAY: begin
        if (cont_zero) begin
          if (passo_q == ULTIMO_PASSO) begin
            estado_d = FIM;
          end else begin
            carregar = 1'b1;
          end
        end
      end
      FIM: begin
        estado_d = IDLE;
      end
      default: begin
        estado_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      passo_q <= '0;
      erro    <= 1'b0;
    end else begin
      if ((estado_q == IDLE) && start) begin
        passo_q <= '0;
        erro    <= 1'b0;
      end else if (ultimo_ciclo) begin
        if (divergencia) begin
          erro <= 1'b1;
        end
        if (passo_q != ULTIMO_PASSO) begin
          passo_q <= passo_q + 3'd1;
        end
      end
    end
  end

  contador_espera #(
    .W(DWELL_W)
  ) u_contador (
    .clock  (clock),
    .reset  (reset),
    .load   (carregar),
    .enable (estado_q == PLAY),
    .valor  (valor_carga),
    .zero   (cont_zero)
  );

  // Outside PLAY the controller sees the idle code and step 0.
  assign codigo = (estado_q == PLAY) ? TAB_CODIGO[passo_q] : 4'b0000;
  assign passo  = (estado_q == PLAY) ? passo_q : 3'd0;
  assign busy   = (estado_q == PLAY);
  assign done   = (estado_q == FIM);
  assign estado = estado_q;

endmodule

// File: tb/tb_sequenciador_porta.sv
// Directed bench for sequenciador_porta: plays full sequences with matching
// and corrupted LED answers, odd dwell values, restarts and mid-run reset.
module tb_sequenciador_porta;
  import sequenciador_porta_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] dwell;
  logic [1:0] led_verde;
  logic [1:0] led_vermelho;
  logic [3:0] codigo;
  logic [2:0] passo;
  logic       busy;
  logic       done;
  logic       erro;
  estado_t    estado;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_cod  [6] = '{4'b0000, 4'b1100, 4'b1101, 4'b0110, 4'b1010, 4'b1000};
  logic [1:0] exp_verde[6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 2'b00};
  logic [1:0] exp_verm [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};

  sequenciador_porta #(
    .DWELL_W(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .dwell        (dwell),
    .led_verde    (led_verde),
    .led_vermelho (led_vermelho),
    .codigo       (codigo),
    .passo        (passo),
    .busy         (busy),
    .done         (done),
    .erro         (erro),
    .estado       (estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plays one sequence cycle by cycle. bad_step forces led_verde=00 on that
  // step, restart_step pulses start on that step's first cycle, hold keeps
  // start high through the end, skip_accept assumes PLAY step 0 already began.
  task automatic run_seq(input int d_in, input int bad_step, input int restart_step,
                         input bit hold, input bit skip_accept);
    int deff;
    int n;
    bit exp_erro;
    deff = (d_in == 0) ? 2 : d_in + 1;
    dwell = 4'(d_in);
    n = 0;
    if (!skip_accept) begin
      start = 1'b1;
      @(posedge clock); #1;
      n = 1;
    end
    if (!hold) start = 1'b0;
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < deff; k++) begin
        led_verde    = (s == bad_step) ? 2'b00 : exp_verde[s];
        led_vermelho = exp_verm[s];
        if (s == restart_step && k == 0) start = 1'b1;
        exp_erro = (bad_step >= 0) && (s > bad_step);
        check("codigo", codigo, exp_cod[s]);
        check("passo", passo, s);
        check("busy", busy, 1);
        check("done_play", done, 0);
        check("erro_play", erro, exp_erro);
        @(posedge clock); #1;
        n++;
        if (s == restart_step && k == 0) start = 1'b0;
      end
    end
    exp_erro = (bad_step >= 0);
    if (!skip_accept) check("latencia", (done === 1'b1) ? n : 0, 6 * deff + 1);
    check("done_fim", done, 1);
    check("estado_fim", estado, FIM);
    check("busy_fim", busy, 0);
    check("codigo_fim", codigo, 0);
    check("passo_fim", passo, 0);
    check("erro_fim", erro, exp_erro);
    @(posedge clock); #1;
    check("done_idle", done, 0);
    check("estado_idle", estado, IDLE);
    check("erro_idle", erro, exp_erro);
    @(posedge clock); #1;
    if (hold) begin
      check("estado_reinicio", estado, PLAY);
      check("passo_reinicio", passo, 0);
      check("erro_reinicio", erro, 0);
    end else begin
      check("estado_fica_idle", estado, IDLE);
      check("busy_fica_idle", busy, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    dwell = 4'd1;
    led_verde = 2'b00;
    led_vermelho = 2'b00;
    #1;
    check("rst_codigo", codigo, 0);
    check("rst_passo", passo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_erro", erro, 0);
    check("rst_estado", estado, IDLE);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Clean run accepted on the first edge after reset release
    run_seq(1, -1, -1, 1'b0, 1'b0);
    // Wrong green pair on step 2; erro sticks through done
    run_seq(1, 2, -1, 1'b0, 1'b0);
    // Next accepted start clears erro
    run_seq(1, -1, -1, 1'b0, 1'b0);
    run_seq(0, -1, -1, 1'b0, 1'b0);
    run_seq(15, -1, -1, 1'b0, 1'b0);
    // start pulse during step 3 is ignored
    run_seq(1, -1, 3, 1'b0, 1'b0);

    // Reset asserted mid step 4 after a step 0 mismatch
    dwell = 4'd1;
    led_verde = 2'b00;
    led_vermelho = 2'b00;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    check("pre_rst_passo", passo, 4);
    check("pre_rst_erro", erro, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_codigo", codigo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_passo", passo, 0);
    check("midrst_erro", erro, 0);
    check("midrst_done", done, 0);
    check("midrst_estado", estado, IDLE);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    check("pos_rst_estado", estado, IDLE);
    run_seq(1, -1, -1, 1'b0, 1'b0);

    // start held high: back-to-back sequences, erro cleared on re-acceptance
    run_seq(1, 2, -1, 1'b1, 1'b0);
    start = 1'b0;
    run_seq(1, -1, -1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
